// File: rtl/psc_pkg.sv
// Shared mode codes, sequencer states and slice-count helpers for the tile-array converter.
package psc_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_P2S  = 2'b01;
    localparam logic [1:0] MODE_S2P  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P2S  = 2'd1,
        ST_S2P  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A zero or oversized request means a full-width word.
    function automatic int eff_len(input int len, input int max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

    function automatic int num_slices(input int len, input int slice, input int max_len = 16);
        int l;
        l = eff_len(len, max_len);
        return (l + slice - 1) / slice;
    endfunction

endpackage

// File: rtl/psc_lane.sv
// One converter lane: word register with slice mux (P2S) and slice demux plus length fix-up (S2P).
// PSC_SIGN_EXT_EN selects sign extension instead of zero fill above the word length.
module psc_lane
    import psc_pkg::*;
#(
    parameter int W  = 16,
    parameter int S  = 4,
    parameter int CW = 3,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic          i_shift,
    input  logic          i_done,
    input  logic          i_drive,
    input  logic          i_en,
    input  logic [CW-1:0] i_cnt,
    input  logic [LW-1:0] i_len,
    input  logic [W-1:0]  i_par,
    input  logic [S-1:0]  i_ser,
    output logic [S-1:0]  o_ser,
    output logic [W-1:0]  o_par
);

    logic [W-1:0] r_word;
    logic [W-1:0] r_out;
    logic         r_en;
    logic [W-1:0] w_asm;
    logic [W-1:0] w_fix;

    // The final slice lands in the same edge that publishes the word, so fix-up uses the merged value.
    always_comb begin
        w_asm = r_word;
        if (i_shift && r_en)
            w_asm[int'(i_cnt)*S +: S] = i_ser;
    end

    always_comb begin
        w_fix = '0;
        for (int b = 0; b < W; b++) begin
            if (b < int'(i_len)) begin
                w_fix[b] = w_asm[b];
            end else begin
`ifdef PSC_SIGN_EXT_EN
                w_fix[b] = w_asm[int'(i_len)-1];
`else
                w_fix[b] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_out  <= '0;
            r_en   <= 1'b0;
        end else begin
            if (i_load) begin
                r_word <= i_par;
                r_en   <= i_en;
            end else if (i_clear) begin
                r_word <= '0;
                r_en   <= i_en;
            end else if (i_shift) begin
                r_word <= w_asm;
            end
            if (i_done)
                r_out <= r_en ? w_fix : '0;
        end
    end

    assign o_ser = (i_drive && r_en) ? r_word[int'(i_cnt)*S +: S] : '0;
    assign o_par = r_out;

endmodule

// File: rtl/psc_tile_array_seq.sv
// Tile-array parallel/serial converter: one sequencer and slice counter drive LANES psc_lane instances.
// PSC_SIGN_EXT_EN enables S2P sign extension (handled inside psc_lane).
module psc_tile_array_seq
    import psc_pkg::*;
#(
    parameter int MAX_WORD_LENGTH = 16,
    parameter int ARRAY_DIM       = 2,
    parameter int TILE_DIM        = 2,
    parameter int SLICE_SIZE      = 4,
    parameter int PE              = 2,
    localparam int LANES = ARRAY_DIM * TILE_DIM * PE,
    localparam int LW    = $clog2(MAX_WORD_LENGTH + 1),
    localparam int CW    = $clog2(MAX_WORD_LENGTH / SLICE_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       mode,
    input  logic                             start,
    input  logic [LW-1:0]                    word_len,
    input  logic [LANES-1:0]                 lane_en,
    input  logic [LANES*MAX_WORD_LENGTH-1:0] parallel_data_in,
    input  logic [LANES*SLICE_SIZE-1:0]      serial_data_in,
    input  logic                             serial_valid_in,
    input  logic                             serial_ready_in,
    output logic [LANES*SLICE_SIZE-1:0]      serial_data_out,
    output logic                             serial_valid_out,
    output logic [LANES*MAX_WORD_LENGTH-1:0] parallel_data_out,
    output logic                             busy,
    output logic                             finish,
    output logic                             err
);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_nsl;
    logic [LW-1:0] r_len;
    logic          r_err;

    logic w_idle_start;
    logic w_load;
    logic w_clear;
    logic w_s2p_shift;
    logic w_last;
    logic w_done;

    assign w_idle_start = start && (r_state == ST_IDLE);
    assign w_load       = w_idle_start && (mode == MODE_P2S);
    assign w_clear      = w_idle_start && (mode == MODE_S2P);
    assign w_s2p_shift  = (r_state == ST_S2P) && serial_valid_in;
    assign w_last       = (r_cnt == r_nsl - CW'(1));
    assign w_done       = w_s2p_shift && w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_nsl   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (mode)
                            MODE_P2S, MODE_S2P: begin
                                r_state <= (mode == MODE_P2S) ? ST_P2S : ST_S2P;
                                r_cnt   <= '0;
                                r_nsl   <= CW'(num_slices(int'(word_len), SLICE_SIZE, MAX_WORD_LENGTH));
                                r_len   <= LW'(eff_len(int'(word_len), MAX_WORD_LENGTH));
                            end
                            MODE_RSVD: r_err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_P2S: begin
                    r_err <= start;
                    if (serial_ready_in) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_S2P: begin
                    r_err <= start;
                    if (serial_valid_in) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_err   <= start;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign serial_valid_out = (r_state == ST_P2S);
    assign busy             = (r_state != ST_IDLE);
    assign finish           = (r_state == ST_DONE);
    assign err              = r_err;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psc_lane #(
            .W (MAX_WORD_LENGTH),
            .S (SLICE_SIZE),
            .CW(CW),
            .LW(LW)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load),
            .i_clear(w_clear),
            .i_shift(w_s2p_shift),
            .i_done (w_done),
            .i_drive(serial_valid_out),
            .i_en   (lane_en[g]),
            .i_cnt  (r_cnt),
            .i_len  (r_len),
            .i_par  (parallel_data_in[g*MAX_WORD_LENGTH +: MAX_WORD_LENGTH]),
            .i_ser  (serial_data_in[g*SLICE_SIZE +: SLICE_SIZE]),
            .o_ser  (serial_data_out[g*SLICE_SIZE +: SLICE_SIZE]),
            .o_par  (parallel_data_out[g*MAX_WORD_LENGTH +: MAX_WORD_LENGTH])
        );
    end

endmodule

// File: tb/tb_psc_tile_array_seq.sv
// Directed bench for psc_tile_array_seq: P2S, stalled P2S, S2P with gaps, error pulses, mid-run reset.
module tb_psc_tile_array_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic         start;
    logic [4:0]   word_len;
    logic [7:0]   lane_en;
    logic [127:0] pdi;
    logic [31:0]  sdi;
    logic         sv_in;
    logic         sr_in;
    logic [31:0]  sdo;
    logic         sv_out;
    logic [127:0] pdo;
    logic         busy;
    logic         finish;
    logic         err;

    int vec  = 0;
    int errs = 0;

`ifdef PSC_SIGN_EXT_EN
    localparam logic [15:0] EXP_A = 16'hFF27;
    localparam logic [15:0] EXP_B = 16'hFFFF;
`else
    localparam logic [15:0] EXP_A = 16'h0F27;
    localparam logic [15:0] EXP_B = 16'h003F;
`endif

    psc_tile_array_seq dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .start            (start),
        .word_len         (word_len),
        .lane_en          (lane_en),
        .parallel_data_in (pdi),
        .serial_data_in   (sdi),
        .serial_valid_in  (sv_in),
        .serial_ready_in  (sr_in),
        .serial_data_out  (sdo),
        .serial_valid_out (sv_out),
        .parallel_data_out(pdo),
        .busy             (busy),
        .finish           (finish),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 2'b00; start = 1'b0; word_len = '0; lane_en = '0;
        pdi = '0; sdi = '0; sv_in = 1'b0; sr_in = 1'b0;
        tick(); tick();
        vec++;
        if ({sv_out, busy, finish, err} !== 4'b0000 || sdo !== 32'h0 || pdo !== 128'h0) begin
            errs++;
            $display("FAIL reset_state: flags=%b sdo=%h pdo=%h required all zero", {sv_out, busy, finish, err}, sdo, pdo);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_p2s_full();
        logic [15:0] w0, w1;
        w0 = 16'hA5C3; w1 = 16'h1234;
        pdi = {96'hDEAD_BEEF_0F0F_F0F0_5555_AAAA, w1, w0};
        lane_en = 8'hFF; word_len = 5'd16; mode = 2'b01; sr_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vec++;
            if ({sv_out, busy, finish} !== 3'b110 || sdo[3:0] !== w0[k*4 +: 4] || sdo[7:4] !== w1[k*4 +: 4]) begin
                errs++;
                $display("FAIL p2s_full_slice%0d: v/b/f=%b l0=%h l1=%h required 110 %h %h", k,
                         {sv_out, busy, finish}, sdo[3:0], sdo[7:4], w0[k*4 +: 4], w1[k*4 +: 4]);
            end
            tick();
        end
        vec++;
        if ({sv_out, busy, finish} !== 3'b011) begin
            errs++;
            $display("FAIL p2s_full_finish: v/b/f=%b required 011", {sv_out, busy, finish});
        end
        tick();
        vec++;
        if ({sv_out, busy, finish, err} !== 4'b0000) begin
            errs++;
            $display("FAIL p2s_full_idle: v/b/f/e=%b required 0000", {sv_out, busy, finish, err});
        end
    endtask

    task automatic test_p2s_stall();
        pdi = {112'h0, 16'hF321};
        lane_en = 8'h01; word_len = 5'd10; mode = 2'b01; sr_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        vec++;
        if (sv_out !== 1'b1 || sdo !== 32'h1) begin
            errs++;
            $display("FAIL p2s_stall_s0: v=%b sdo=%h required 1 00000001", sv_out, sdo);
        end
        tick();
        sr_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vec++;
            if ({sv_out, finish} !== 2'b10 || sdo !== 32'h2) begin
                errs++;
                $display("FAIL p2s_stall_hold%0d: v/f=%b sdo=%h required 10 00000002", k, {sv_out, finish}, sdo);
            end
            tick();
        end
        sr_in = 1'b1;
        vec++;
        if (sv_out !== 1'b1 || sdo !== 32'h2) begin
            errs++;
            $display("FAIL p2s_stall_s1: v=%b sdo=%h required 1 00000002", sv_out, sdo);
        end
        tick();
        vec++;
        if ({sv_out, finish} !== 2'b10 || sdo !== 32'h3) begin
            errs++;
            $display("FAIL p2s_stall_s2: v/f=%b sdo=%h required 10 00000003", {sv_out, finish}, sdo);
        end
        tick();
        vec++;
        if ({sv_out, finish} !== 2'b01 || sdo !== 32'h0) begin
            errs++;
            $display("FAIL p2s_stall_finish: v/f=%b sdo=%h required 01 00000000", {sv_out, finish}, sdo);
        end
        tick();
    endtask

    task automatic test_s2p();
        logic [127:0] exp1, exp2;
        exp1 = {112'h0, EXP_A};
        exp2 = {96'h0, EXP_B, 16'h0};
        lane_en = 8'h01; word_len = 5'd12; mode = 2'b10; start = 1'b1; sr_in = 1'b0;
        tick();
        start = 1'b0; sv_in = 1'b1; sdi = {8{4'h7}};
        tick();
        sv_in = 1'b0; sdi = {8{4'hC}};
        vec++;
        if ({busy, finish} !== 2'b10 || pdo !== 128'h0) begin
            errs++;
            $display("FAIL s2p_gap_hold: b/f=%b pdo=%h required 10 0", {busy, finish}, pdo);
        end
        tick();
        sv_in = 1'b1; sdi = {8{4'h2}};
        tick();
        sdi = {8{4'hF}};
        tick();
        sv_in = 1'b0;
        vec++;
        if ({busy, finish} !== 2'b11 || pdo !== exp1) begin
            errs++;
            $display("FAIL s2p_len12_word: b/f=%b pdo=%h required 11 %h", {busy, finish}, pdo, exp1);
        end
        tick();
        vec++;
        if ({busy, finish} !== 2'b00 || pdo !== exp1) begin
            errs++;
            $display("FAIL s2p_len12_hold: b/f=%b pdo=%h required 00 %h", {busy, finish}, pdo, exp1);
        end
        lane_en = 8'h02; word_len = 5'd6; mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0; sv_in = 1'b1; sdi = {8{4'hF}};
        vec++;
        if (pdo !== exp1) begin
            errs++;
            $display("FAIL s2p_len6_prev: pdo=%h required %h", pdo, exp1);
        end
        tick();
        tick();
        sv_in = 1'b0;
        vec++;
        if (finish !== 1'b1 || pdo !== exp2) begin
            errs++;
            $display("FAIL s2p_len6_word: f=%b pdo=%h required 1 %h", finish, pdo, exp2);
        end
        tick();
    endtask

    task automatic test_err();
        lane_en = 8'h01; pdi = {112'h0, 16'h0009}; word_len = 5'd4; sr_in = 1'b1;
        mode = 2'b00; start = 1'b1;
        tick();
        vec++;
        if ({busy, err} !== 2'b00) begin
            errs++;
            $display("FAIL mode_idle_start: b/e=%b required 00", {busy, err});
        end
        mode = 2'b11;
        tick();
        start = 1'b0;
        vec++;
        if ({busy, finish, err} !== 3'b001) begin
            errs++;
            $display("FAIL rsvd_err: b/f/e=%b required 001", {busy, finish, err});
        end
        tick();
        vec++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL rsvd_err_pulse: e=%b required 0", err);
        end
        mode = 2'b01; start = 1'b1;
        tick();
        mode = 2'b10;
        vec++;
        if ({sv_out, err} !== 2'b10 || sdo !== 32'h9) begin
            errs++;
            $display("FAIL busy_first: v/e=%b sdo=%h required 10 00000009", {sv_out, err}, sdo);
        end
        tick();
        mode = 2'b01;
        vec++;
        if ({busy, finish, err} !== 3'b111) begin
            errs++;
            $display("FAIL busy_start_err: b/f/e=%b required 111", {busy, finish, err});
        end
        tick();
        start = 1'b0;
        vec++;
        if ({busy, finish, err, sv_out} !== 4'b0010) begin
            errs++;
            $display("FAIL done_start_rej: b/f/e/v=%b required 0010", {busy, finish, err, sv_out});
        end
        tick();
        vec++;
        if ({busy, finish, err, sv_out} !== 4'b0000) begin
            errs++;
            $display("FAIL err_settle: b/f/e/v=%b required 0000", {busy, finish, err, sv_out});
        end
    endtask

    task automatic test_reset_mid();
        int fin_seen;
        fin_seen = 0;
        lane_en = 8'hFF; pdi = {8{16'h4321}}; word_len = 5'd16; mode = 2'b01; sr_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        vec++;
        if ({sv_out, busy, finish, err} !== 4'b0000 || sdo !== 32'h0 || pdo !== 128'h0) begin
            errs++;
            $display("FAIL reset_async: flags=%b sdo=%h pdo=%h required all zero", {sv_out, busy, finish, err}, sdo, pdo);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (finish !== 1'b0) fin_seen++;
        end
        reset = 1'b0;
        tick();
        if (finish !== 1'b0) fin_seen++;
        vec++;
        if (fin_seen != 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_finish: finish_cycles=%0d busy=%b required 0 0", fin_seen, busy);
        end
        pdi = {112'h0, 16'h00B7}; lane_en = 8'h01; word_len = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        vec++;
        if (sv_out !== 1'b1 || sdo !== 32'h7) begin
            errs++;
            $display("FAIL restart_s0: v=%b sdo=%h required 1 00000007", sv_out, sdo);
        end
        tick();
        vec++;
        if (sv_out !== 1'b1 || sdo !== 32'hB) begin
            errs++;
            $display("FAIL restart_s1: v=%b sdo=%h required 1 0000000b", sv_out, sdo);
        end
        tick();
        vec++;
        if ({sv_out, finish} !== 2'b01) begin
            errs++;
            $display("FAIL restart_finish: v/f=%b required 01", {sv_out, finish});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_p2s_full();
        test_p2s_stall();
        test_s2p();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/psc_tile_array_seq.md
Name: psc_tile_array_seq

Overview:
- Parametrised successor to the tile-level parallel/serial converter array: LANES = ARRAY_DIM*TILE_DIM*PE independent lanes.
- Converts parallel words to SLICE_SIZE-bit slices (P2S) or slices back to words (S2P).
- One central sequencer, runtime word length, per-lane enable mask, valid/ready handshakes on the serial side, and a single aggregated finish pulse.
- Sits between the bit-sliced PE array and the operand/result buffers.

Parameters:
- MAX_WORD_LENGTH, 16, max bits per lane word; must be a multiple of SLICE_SIZE.
- ARRAY_DIM, 2, tiles per array.
- TILE_DIM, 2, blocks per tile.
- SLICE_SIZE, 4, bits per serial slice per lane.
- PE, 2, lanes per block.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  00 idle, 01 P2S, 10 S2P, 11 reserved; sampled on accepted start.
- start  in  1  single-cycle request; accepted only in IDLE.
- word_len  in  $clog2(MAX_WORD_LENGTH+1)  bits per word, sampled on start; 0 or >MAX means MAX_WORD_LENGTH.
- lane_en  in  LANES  per-lane enable, sampled on start.
- parallel_data_in  in  LANES*MAX_WORD_LENGTH  P2S source words, captured on accepted start.
- serial_data_in  in  LANES*SLICE_SIZE  S2P slices.
- serial_valid_in  in  1  S2P slice present.
- serial_ready_in  in  1  downstream accepts P2S slice.
- serial_data_out  out  LANES*SLICE_SIZE  P2S slices, LSB slice first.
- serial_valid_out  out  1  P2S slice valid.
- parallel_data_out  out  LANES*MAX_WORD_LENGTH  S2P assembled words.
- busy  out  1  sequencer not in IDLE.
- finish  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset: all outputs 0; state IDLE; lane registers and slice counter 0. Reset mid-operation aborts immediately with no finish pulse.
- N = ceil(eff_len/SLICE_SIZE), where eff_len is word_len after the 0/>MAX substitution.
- States: IDLE, P2S_SHIFT, S2P_SHIFT, DONE.
- IDLE:
  - start & mode=01: capture words and mask, cnt=0, go to P2S_SHIFT.
  - start & mode=10: clear assembly registers, cnt=0, go to S2P_SHIFT.
  - start & mode=00: no action.
  - start & mode=11: err=1 for one cycle, stay IDLE.
- P2S_SHIFT:
  - serial_valid_out=1; each lane drives slice cnt of its captured word.
  - Advance only when serial_ready_in=1.
  - After the slice with cnt=N-1 is accepted, go to DONE.
  - When serial_ready_in=0, data and valid are held stable.
- S2P_SHIFT:
  - On serial_valid_in=1, each enabled lane writes its slice to bits [cnt*SLICE_SIZE +: SLICE_SIZE]; cnt++.
  - After the Nth accepted slice, go to DONE.
  - Bits at or above eff_len are forced to 0.
  - parallel_data_out updates only on entry to DONE (registered copy), so it holds its previous value during assembly.
- DONE: finish=1 for exactly one cycle; next state IDLE; serial_valid_out=0.
- Disabled lanes: serial_data_out slice is 0; parallel_data_out word is 0 after the operation.
- Latency with ready/valid held high:
  - P2S: start at cycle 0; first slice valid at cycle 1; last at cycle N; finish at cycle N+1.
  - S2P: slices at cycles 1..N; parallel_data_out and finish at cycle N+1.
- start while busy: ignored; err pulses; the running operation is unaffected.
- busy=1 in every state except IDLE, including DONE.
- start in the same cycle finish is asserted is rejected, because the sequencer is still in DONE.

Optional Feature:
- Macro: PSC_SIGN_EXT_EN.
- Defined: S2P sign-extends each enabled lane from bit eff_len-1 up to MAX_WORD_LENGTH-1 at DONE.
- Undefined: upper bits are zero-filled.
- P2S behaviour is identical either way.

Decomposition:
- Package psc_pkg holds:
  - mode localparams MODE_IDLE, MODE_P2S, MODE_S2P, MODE_RSVD;
  - state encoding;
  - function num_slices(len, slice) implementing ceil-division with the 0/>MAX substitution.
- Sub-module psc_lane, instantiated LANES times: one word register plus slice mux/demux, driven by shared cnt, load, shift and enable.
- The sequencer FSM and counter stay in the top module.

Test Plan:
- P2S, word_len=16, all lanes on, lane0 word 16'hA5C3, ready high -> slices 3,C,5,A at cycles 1-4; finish at cycle 5.
- P2S, word_len=10, ready low at cycle 2 for 3 cycles -> slice 1 held stable for 3 cycles; 3 slices total; finish 3 cycles later than the unstalled case.
- S2P, word_len=12, lane_en=...01, slices 7,2,F with a valid gap -> lane0 word 16'h0F27; other lanes 0; finish one cycle after the 3rd slice.
- With PSC_SIGN_EXT_EN, same S2P stimulus -> lane0 word 16'hFF27.
- start with mode=11, and start while busy -> err pulse; no state change; no extra finish.
- reset asserted mid-P2S -> all outputs 0 asynchronously; no finish; a fresh start afterwards completes normally.
